// File: rtl/usb_pkg.sv
// Shared definitions for the FT245-style USB FIFO bridge: frame layout,
// transmitter FSM states and the status-frame checksum helper.
package usb_pkg;

   localparam logic [7:0]  FRAME_HDR = 8'hA5;
   localparam int unsigned FRAME_LEN = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TXE,
      ST_SETUP,
      ST_WR_HI,
      ST_HOLD,
      ST_SI,
      ST_FIN
   } tx_state_t;

   // Checksum byte: XOR of the four payload bytes (frame indices 1-4)
   function automatic logic [7:0] frame_checksum(input logic [4:0] st,
                                                 input logic [7:0] freq,
                                                 input logic [7:0] amp,
                                                 input logic [7:0] phase);
      return {3'b000, st} ^ freq ^ amp ^ phase;
   endfunction

endpackage

// File: rtl/usb_tx_frame_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops to settle the asynchronous input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_tx_frame.sv
// Host-bound status-frame transmitter for the FT245-style FIFO bridge.
// Snapshots generator settings on req and writes a 6-byte frame using the
// asynchronous write strobe, gated by synchronized TXE#.
// Optional feature macro: USB_TX_SI_EN (Send-Immediate pulse after byte 5).
module usb_tx_frame #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned WR_HI_CYC = 4,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned SI_CYC    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [4:0] state,
   input  logic [7:0] state_freq,
   input  logic [7:0] state_amp,
   input  logic [7:0] state_phase,
   output logic       busy,
   output logic       done,
   input  logic       txe,
   output logic       wr,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic       si
);

   import usb_pkg::*;

   // WAIT_TXE ignores txe_s for this many cycles so that the TXE# response
   // to the previous write has made it through the synchronizer.
   localparam int unsigned SYNC_CYC = 2;

   localparam int unsigned MAX_AB  = (SETUP_CYC > WR_HI_CYC) ? SETUP_CYC : WR_HI_CYC;
   localparam int unsigned MAX_CD  = (HOLD_CYC > SI_CYC) ? HOLD_CYC : SI_CYC;
   localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_MAX = (MAX_P > SYNC_CYC) ? MAX_P : SYNC_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

   tx_state_t              tx_st;
   logic [2:0]             idx;
   logic [CNT_W-1:0]       cnt;
   logic [FRAME_LEN-1:0][7:0] frame;
   logic                   txe_s;

   sync2 #(.RST_VAL(1'b1)) u_txe_sync (
      .clk (clk),
      .rst (rst),
      .d   (txe),
      .q   (txe_s)
   );

`ifdef USB_TX_SI_EN
   logic si_r;
   assign si = si_r;
`else
   assign si = 1'b1;
`endif

   // Frame sequencer: snapshot, per-byte TXE# gating, write strobe timing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st <= ST_IDLE;
         idx   <= '0;
         cnt   <= '0;
         frame <= '0;
         wr    <= 1'b0;
         d_oe  <= 1'b0;
         d_out <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef USB_TX_SI_EN
         si_r  <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         case (tx_st)
            ST_IDLE: begin
               if (req) begin
                  frame <= {frame_checksum(state, state_freq, state_amp, state_phase),
                            state_phase, state_amp, state_freq, {3'b000, state}, FRAME_HDR};
                  idx   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  tx_st <= ST_WAIT_TXE;
               end
            end
            ST_WAIT_TXE: begin
               if (cnt < CNT_W'(SYNC_CYC)) begin
                  cnt <= cnt + CNT_W'(1);
               end else if (!txe_s) begin
                  cnt   <= '0;
                  d_oe  <= 1'b1;
                  d_out <= frame[idx];
                  tx_st <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                  cnt   <= '0;
                  wr    <= 1'b1;
                  tx_st <= ST_WR_HI;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WR_HI: begin
               if (cnt == CNT_W'(WR_HI_CYC - 1)) begin
                  cnt   <= '0;
                  wr    <= 1'b0;
                  tx_st <= ST_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                  cnt  <= '0;
                  d_oe <= 1'b0;
                  if (idx < LAST_IDX) begin
                     idx   <= idx + 3'd1;
                     tx_st <= ST_WAIT_TXE;
                  end else begin
`ifdef USB_TX_SI_EN
                     si_r  <= 1'b0;
                     tx_st <= ST_SI;
`else
                     tx_st <= ST_FIN;
`endif
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`ifdef USB_TX_SI_EN
            ST_SI: begin
               if (cnt == CNT_W'(SI_CYC - 1)) begin
                  cnt   <= '0;
                  si_r  <= 1'b1;
                  tx_st <= ST_FIN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            ST_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               idx   <= '0;
               tx_st <= ST_IDLE;
            end
            default: begin
               tx_st <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_frame.sv
// Self-checking bench for usb_tx_frame: table-driven frames plus directed
// sequences for TXE# stall, snapshot/ignored request and mid-frame reset.
module tb_usb_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [4:0] state;
   logic [7:0] state_freq, state_amp, state_phase;
   logic       busy, done, txe, wr, d_oe, si;
   logic [7:0] d_out;

   int errors = 0;
   int checks = 0;

   usb_tx_frame dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .state       (state),
      .state_freq  (state_freq),
      .state_amp   (state_amp),
      .state_phase (state_phase),
      .busy        (busy),
      .done        (done),
      .txe         (txe),
      .wr          (wr),
      .d_out       (d_out),
      .d_oe        (d_oe),
      .si          (si)
   );

   always #5 clk = ~clk;

`ifdef USB_TX_SI_EN
   localparam int EXP_SI_LOW    = 4;
   localparam int EXP_DONE_LAT  = 6;
`else
   localparam int EXP_SI_LOW    = 0;
   localparam int EXP_DONE_LAT  = 2;
`endif

   typedef struct {
      logic [4:0]       st;
      logic [7:0]       freq;
      logic [7:0]       amp;
      logic [7:0]       phase;
      logic [5:0][7:0]  exp;
   } vec_t;

   vec_t vecs [5];

   // ---------------- bus monitor ----------------
   int          cyc = 0;
   logic        wr_prev = 1'b0, oe_prev = 1'b0;
   logic [7:0]  held = '0;
   logic [7:0]  byte_q [$];
   int          rise_q [$];
   int          fall_q [$];
   int          oe_rise_q [$];
   int          si_low = 0, done_cnt = 0, done_cyc = 0, bus_err = 0, stab_err = 0;

   always begin
      @(posedge clk);
      cyc++;
      #1;
      if (wr && !wr_prev) rise_q.push_back(cyc);
      if (!wr && wr_prev) begin
         fall_q.push_back(cyc);
         byte_q.push_back(d_out);
         if (!d_oe) bus_err++;
      end
      if (d_oe && !oe_prev) begin
         oe_rise_q.push_back(cyc);
         held = d_out;
      end else if (d_oe && d_out !== held) begin
         stab_err++;
      end
      if (wr && !d_oe) bus_err++;
      if (!si) si_low++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      wr_prev = wr;
      oe_prev = d_oe;
   end

   task automatic clear_mon();
      byte_q.delete(); rise_q.delete(); fall_q.delete(); oe_rise_q.delete();
      si_low = 0; done_cnt = 0; done_cyc = 0; bus_err = 0; stab_err = 0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic set_inputs(input vec_t v);
      state = v.st; state_freq = v.freq; state_amp = v.amp; state_phase = v.phase;
   endtask

   // Pulse req for one cycle; returns the cycle number at which it was sampled
   task automatic pulse_req(output int req_cyc);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req_cyc = cyc;
      check("busy_rise", {31'd0, busy}, 32'd1);
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'd0, (done_cnt > 0)}, 32'd1);
      check("busy_fall", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_frame(input string tag, input logic [5:0][7:0] exp,
                              input int req_cyc, input bit check_lat);
      int bad_w = 0;
      logic [31:0] got;
      check({tag, "_nbytes"}, byte_q.size(), 32'd6);
      for (int i = 0; i < 6; i++) begin
         got = (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hDEAD;
         check($sformatf("%s_byte%0d", tag, i), got, {24'd0, exp[i]});
      end
      for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++)
         if (fall_q[i] - rise_q[i] != 4) bad_w++;
      check({tag, "_wr_width"}, bad_w, 32'd0);
      if (check_lat && rise_q.size() > 0)
         check({tag, "_first_wr_lat"}, rise_q[0] - req_cyc, 32'd5);
      if (fall_q.size() > 0)
         check({tag, "_done_lat"}, done_cyc - fall_q[fall_q.size()-1], EXP_DONE_LAT);
      check({tag, "_si_low"}, si_low, EXP_SI_LOW);
      check({tag, "_done_pulses"}, done_cnt, 32'd1);
      check({tag, "_bus_err"}, bus_err, 32'd0);
      check({tag, "_stable"}, stab_err, 32'd0);
   endtask

   // Wait (bounded) until the monitor has seen n write falls
   task automatic wait_falls(input int n, input string name);
      int k = 0;
      while (fall_q.size() < n && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, {31'd0, (fall_q.size() >= n)}, 32'd1);
   endtask

   initial begin
      int rc;
      int k;
      int stall_bad;
      int txe_fall_cyc;

      vecs[0] = '{st: 5'h03, freq: 8'h10, amp: 8'h80, phase: 8'h00,
                  exp: {8'h93, 8'h00, 8'h80, 8'h10, 8'h03, 8'hA5}};
      vecs[1] = '{st: 5'h1F, freq: 8'hFF, amp: 8'h00, phase: 8'h55,
                  exp: {8'hB5, 8'h55, 8'h00, 8'hFF, 8'h1F, 8'hA5}};
      vecs[2] = '{st: 5'h00, freq: 8'h00, amp: 8'h00, phase: 8'h00,
                  exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
      vecs[3] = '{st: 5'h12, freq: 8'h34, amp: 8'h56, phase: 8'h78,
                  exp: {8'h08, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA5}};
      vecs[4] = '{st: 5'h1F, freq: 8'hAA, amp: 8'h55, phase: 8'hFF,
                  exp: {8'h1F, 8'hFF, 8'h55, 8'hAA, 8'h1F, 8'hA5}};

      rst = 1'b1; req = 1'b0; txe = 1'b0;
      set_inputs(vecs[0]);
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_wr",    {31'd0, wr},   32'd0);
      check("rst_d_oe",  {31'd0, d_oe}, 32'd0);
      check("rst_d_out", {24'd0, d_out}, 32'd0);
      check("rst_si",    {31'd0, si},   32'd1);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Table-driven frames with TXE# held low
      for (int v = 0; v < 5; v++) begin
         set_inputs(vecs[v]);
         clear_mon();
         pulse_req(rc);
         wait_done(300);
         repeat (2) @(negedge clk);
         check_frame($sformatf("vec%0d", v), vecs[v].exp, rc, 1'b1);
      end

      // TXE# stall of 20 cycles before byte 2
      set_inputs(vecs[0]);
      clear_mon();
      pulse_req(rc);
      wait_falls(2, "stall_reach_byte2");
      txe = 1'b1;
      stall_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr || (d_oe && i > 2)) stall_bad++;
      end
      check("stall_bus_idle", stall_bad, 32'd0);
      check("stall_oe_count", oe_rise_q.size(), 32'd2);
      txe_fall_cyc = cyc;
      txe = 1'b0;
      wait_done(300);
      repeat (2) @(negedge clk);
      if (oe_rise_q.size() > 2)
         check("stall_oe_resume", oe_rise_q[2] - txe_fall_cyc, 32'd3);
      else
         check("stall_oe_resume", 32'hDEAD, 32'd3);
      check_frame("stall", vecs[0].exp, rc, 1'b0);

      // Snapshot: inputs change and a second req arrives mid-frame
      set_inputs(vecs[3]);
      clear_mon();
      pulse_req(rc);
      repeat (6) @(negedge clk);
      set_inputs(vecs[1]);
      wait_falls(3, "snap_reach_byte3");
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_done(300);
      repeat (40) @(negedge clk);
      check_frame("snap", vecs[3].exp, rc, 1'b1);
      check("snap_busy_idle", {31'd0, busy}, 32'd0);

      // Reset during WR_HI of byte 3, then a fresh full frame
      set_inputs(vecs[4]);
      clear_mon();
      pulse_req(rc);
      wait_falls(3, "rst_reach_byte3");
      k = 0;
      while (!wr && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rst_in_wr_hi", {31'd0, wr}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_wr",   {31'd0, wr},   32'd0);
      check("rst_async_d_oe", {31'd0, d_oe}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_no_resume", {31'd0, (wr | d_oe | busy)}, 32'd0);
      set_inputs(vecs[2]);
      clear_mon();
      pulse_req(rc);
      wait_done(300);
      repeat (2) @(negedge clk);
      check_frame("after_rst", vecs[2].exp, rc, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
